// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the port not served last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = 1'b0;
    if (req0 && req1) begin
      gnt_id = ~last;
    end else begin
      gnt_id = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises core and loader accesses onto the single-port data memory,
// holding each access for MEM_LAT cycles and acking the winner for one cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] adr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  state_t             state;
  logic               last;
  logic               id_q;
  logic               we_q;
  logic [CNT_W-1:0]   cnt;

  logic               gnt_valid;
  logic               gnt_id;
  logic               sel_we;
  logic [AW-1:0]      sel_adr;
  logic [DW-1:0]      sel_wdata;

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign sel_we    = gnt_id ? we1    : we0;
  assign sel_adr   = gnt_id ? adr1   : adr0;
  assign sel_wdata = gnt_id ? wdata1 : wdata0;

  // mem_adr / mem_wdata double as the latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      id_q      <= 1'b0;
      we_q      <= 1'b0;
      cnt       <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            state     <= ACCESS;
            id_q      <= gnt_id;
            last      <= gnt_id;
            we_q      <= sel_we;
            mem_adr   <= sel_adr;
            mem_wdata <= sel_wdata;
            mem_read  <= ~sel_we;
            mem_write <= sel_we;
            cnt       <= CNT_W'(MEM_LAT - 1);
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          // Last memory cycle: capture read data and hand over to DONE.
          if (cnt == '0) begin
            state     <= DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ack0      <= ~id_q;
            ack1      <= id_q;
            if (!we_q) begin
              rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: three arbiters (MEM_LAT 1, 3, 4) against a cycle-timeline model.
module tb_mem_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 0;

  logic        req0_a[N], req1_a[N], we0_a[N], we1_a[N];
  logic [31:0] adr0_a[N], adr1_a[N], wd0_a[N], wd1_a[N];
  logic        ack0_a[N], ack1_a[N], busy_a[N], mrd_a[N], mwr_a[N];
  logic [31:0] rdata_a[N], madr_a[N], mwd_a[N];

  // hand-computed timing per instance (MEM_LAT = 1, 3, 4)
  int exp_dly[N] = '{2, 4, 5};
  int exp_stb[N] = '{1, 3, 4};
  int exp_gap[N] = '{3, 5, 6};

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'hDEAD_BEEF : (32'h1000_0000 + 32'(i));
  endfunction

  for (genvar k = 0; k < N; k++) begin : g
    localparam int unsigned L = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    logic        ack0, ack1, busy, mem_read, mem_write;
    logic [31:0] rdata, mem_adr, mem_wdata, mem_rdata;
    logic [31:0] mem [16];

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) dut (
      .clk(clk), .rst(rst),
      .req0(req0_a[k]), .we0(we0_a[k]), .adr0(adr0_a[k]), .wdata0(wd0_a[k]),
      .req1(req1_a[k]), .we1(we1_a[k]), .adr1(adr1_a[k]), .wdata1(wd1_a[k]),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
      .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_adr[3:0]];

    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      end else if (mem_write) begin
        mem[mem_adr[3:0]] <= mem_wdata;
      end
    end

    assign ack0_a[k]  = ack0;
    assign ack1_a[k]  = ack1;
    assign busy_a[k]  = busy;
    assign mrd_a[k]   = mem_read;
    assign mwr_a[k]   = mem_write;
    assign rdata_a[k] = rdata;
    assign madr_a[k]  = mem_adr;
    assign mwd_a[k]   = mem_wdata;
  end

  // Model: each access is a timeline (grant cycle g, memory busy g+1..g+L, ack g+L+1).
  int          m_g[N], m_free[N];
  logic        m_gid[N], m_gwe[N], m_last[N];
  logic [31:0] m_gadr[N], m_gwd[N], m_rdata[N], m_madr[N], m_mwd[N];
  logic [31:0] shadow[N][16];
  bit          pend[N][2];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h", name, k, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic win;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        started   = 1;
        m_free[k] = cyc + 1;
        m_g[k]    = -100;
        m_last[k] = 1'b1;
        m_gid[k]  = 1'b0;
        m_gwe[k]  = 1'b0;
        m_rdata[k] = '0;
        m_madr[k]  = '0;
        m_mwd[k]   = '0;
        for (int i = 0; i < 16; i++) shadow[k][i] = init_word(i);
      end else begin
        if (cyc == m_g[k] + lat_of(k)) begin
          if (m_gwe[k]) shadow[k][m_gadr[k][3:0]] = m_gwd[k];
          else          m_rdata[k] = shadow[k][m_gadr[k][3:0]];
        end
        if (cyc >= m_free[k] && (req0_a[k] || req1_a[k])) begin
          if (req0_a[k] && req1_a[k]) win = ~m_last[k];
          else                        win = req1_a[k];
          m_last[k]  = win;
          m_gid[k]   = win;
          m_g[k]     = cyc;
          m_free[k]  = cyc + lat_of(k) + 2;
          m_gwe[k]   = win ? we1_a[k]  : we0_a[k];
          m_gadr[k]  = win ? adr1_a[k] : adr0_a[k];
          m_gwd[k]   = win ? wd1_a[k]  : wd0_a[k];
          m_madr[k]  = m_gadr[k];
          m_mwd[k]   = m_gwd[k];
        end
      end
    end
  endtask

  task automatic compare_all();
    bit acc, ack;
    for (int k = 0; k < N; k++) begin
      acc = (cyc >= m_g[k] + 1) && (cyc <= m_g[k] + lat_of(k));
      ack = (cyc == m_g[k] + lat_of(k) + 1);
      chk("ack0",      k, ack0_a[k], ack && !m_gid[k]);
      chk("ack1",      k, ack1_a[k], ack &&  m_gid[k]);
      chk("busy",      k, busy_a[k], acc || ack);
      chk("mem_read",  k, mrd_a[k],  acc && !m_gwe[k]);
      chk("mem_write", k, mwr_a[k],  acc &&  m_gwe[k]);
      chk("rdata",     k, rdata_a[k], m_rdata[k]);
      chk("mem_adr",   k, madr_a[k],  m_madr[k]);
      chk("mem_wdata", k, mwd_a[k],   m_mwd[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    if (started) compare_all();
  endtask

  task automatic drive(input int k, input int p, input logic rq, input logic we,
                       input logic [31:0] adr, input logic [31:0] wd);
    if (p == 0) begin
      req0_a[k] = rq; we0_a[k] = we; adr0_a[k] = adr; wd0_a[k] = wd;
    end else begin
      req1_a[k] = rq; we1_a[k] = we; adr1_a[k] = adr; wd1_a[k] = wd;
    end
  endtask

  task automatic set_req(input int k, input int p, input logic rq);
    if (p == 0) req0_a[k] = rq;
    else        req1_a[k] = rq;
  endtask

  function automatic bit exp_ack(input int k, input int p);
    return (cyc == m_g[k] + lat_of(k) + 1) && (int'(m_gid[k]) == p);
  endfunction

  function automatic bit in_acc(input int k, input int p);
    return (int'(m_gid[k]) == p) && (cyc >= m_g[k] + 1) && (cyc <= m_g[k] + lat_of(k));
  endfunction

  // One access on all instances; request dropped once granted.
  task automatic run_one(input int p, input logic we, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
    int t;
    int dly[N], other[N], stb[N];
    for (int k = 0; k < N; k++) begin
      dly[k] = -1; other[k] = 0; stb[k] = 0;
      drive(k, p, 1'b1, we, adr, wd);
    end
    t = cyc;
    tick();
    for (int k = 0; k < N; k++) set_req(k, p, 1'b0);
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < N; k++) begin
        if ((p == 1) ? ack1_a[k] : ack0_a[k]) dly[k] = cyc - t;
        if ((p == 1) ? ack0_a[k] : ack1_a[k]) other[k]++;
        if (we ? mwr_a[k] : mrd_a[k]) stb[k]++;
      end
      tick();
    end
    for (int k = 0; k < N; k++) begin
      chk({tag, "_ack_delay"}, k, dly[k], exp_dly[k]);
      chk({tag, "_strobe_cycles"}, k, stb[k], exp_stb[k]);
      chk({tag, "_other_ack"}, k, other[k], 0);
      chk({tag, "_rdata"}, k, rdata_a[k], exp_rd);
    end
  endtask

  initial begin
    int t;
    int ap[N][4], ac[N][4], na[N];

    for (int k = 0; k < N; k++) begin
      drive(k, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(k, 1, 1'b0, 1'b0, 32'd0, 32'd0);
      pend[k][0] = 0; pend[k][1] = 0;
    end

    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < N; k++) begin
      chk("reset_busy", k, busy_a[k], 0);
      chk("reset_ack0", k, ack0_a[k], 0);
      chk("reset_ack1", k, ack1_a[k], 0);
      chk("reset_strobes", k, {mrd_a[k], mwr_a[k]}, 0);
      chk("reset_mem_adr", k, madr_a[k], 0);
      chk("reset_rdata", k, rdata_a[k], 0);
    end
    rst = 1'b0;

    // idle with a wiggling, unrequested address on port 1
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < N; k++) adr1_a[k] = $urandom;
      tick();
      for (int k = 0; k < N; k++) begin
        chk("idle_busy", k, busy_a[k], 0);
        chk("idle_mem_adr", k, madr_a[k], 0);
        chk("idle_ack1", k, ack1_a[k], 0);
      end
    end
    for (int k = 0; k < N; k++) adr1_a[k] = 32'd0;

    run_one(0, 1'b0, 32'd5, 32'd0,      32'hDEAD_BEEF, "rd5");
    run_one(1, 1'b1, 32'd8, 32'h1234,   32'hDEAD_BEEF, "wr8");
    run_one(1, 1'b0, 32'd8, 32'd0,      32'h0000_1234, "rd8");

    // contention straight out of reset, both ports held continuously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      drive(k, 0, 1'b1, 1'b0, 32'd3, 32'd0);
      drive(k, 1, 1'b1, 1'b0, 32'd4, 32'd0);
      na[k] = 0;
      for (int j = 0; j < 4; j++) begin ap[k][j] = -1; ac[k][j] = -1; end
    end
    t = cyc;
    for (int i = 0; i < 26; i++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if ((ack0_a[k] || ack1_a[k]) && na[k] < 4) begin
          ap[k][na[k]] = ack1_a[k] ? 1 : 0;
          ac[k][na[k]] = cyc;
          na[k]++;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      chk("tie_ack_count", k, na[k], 4);
      chk("tie_first_port", k, ap[k][0], 0);
      chk("tie_first_delay", k, ac[k][0] - t, exp_dly[k]);
      chk("tie_second_port", k, ap[k][1], 1);
      chk("tie_second_gap", k, ac[k][1] - ac[k][0], exp_gap[k]);
      chk("tie_third_port", k, ap[k][2], 0);
      chk("tie_fourth_port", k, ap[k][3], 1);
      set_req(k, 0, 1'b0);
      set_req(k, 1, 1'b0);
    end
    for (int i = 0; i < 8; i++) tick();

    // reset during the second memory cycle of the MEM_LAT=4 instance
    for (int k = 0; k < N; k++) drive(k, 0, 1'b1, 1'b0, 32'd5, 32'd0);
    tick();
    for (int k = 0; k < N; k++) set_req(k, 0, 1'b0);
    tick();
    chk("abort_in_access", 2, mrd_a[2], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_mem_read", 2, mrd_a[2], 0);
    chk("abort_busy", 2, busy_a[2], 0);
    chk("abort_ack0", 2, ack0_a[2], 0);
    chk("abort_rdata", 2, rdata_a[2], 0);
    t = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack0_a[2] || ack1_a[2]) t++;
    end
    chk("abort_no_late_ack", 2, t, 0);

    // randomized traffic with occasional resets
    for (int it = 0; it < 2500; it++) begin
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
          for (int p = 0; p < 2; p++) begin
            pend[k][p] = 0;
            set_req(k, p, 1'b0);
          end
        end
      end
      if (!rst) begin
        for (int k = 0; k < N; k++) begin
          for (int p = 0; p < 2; p++) begin
            if (pend[k][p] && exp_ack(k, p)) begin
              pend[k][p] = 0;
              if ($urandom_range(0, 1) == 1) begin
                drive(k, p, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom);
                pend[k][p] = 1;
              end else begin
                set_req(k, p, 1'b0);
              end
            end else if (pend[k][p]) begin
              if (in_acc(k, p) && $urandom_range(0, 7) == 0) set_req(k, p, 1'b0);
            end else if ($urandom_range(0, 2) == 0) begin
              drive(k, p, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom);
              pend[k][p] = 1;
            end else if (p == 0) begin
              adr0_a[k] = $urandom;
            end else begin
              adr1_a[k] = $urandom;
            end
          end
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port data memory (`data_mem`) between the multi-cycle MIPS core and a second master (boot loader / DMA). It serialises accesses with round-robin priority and holds each access on the memory port for a fixed number of cycles. It returns read data and a one-cycle acknowledge to the winning requester. It sits between the masters and `data_mem` in the top level, replacing the direct core-to-memory connection.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MEM_LAT`, 1, cycles each access is held on the memory port (legal range 1..15)

- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `req0` / `req1` in 1: request from port 0 (core) / port 1 (loader)
- `we0` / `we1` in 1: 1 = write, 0 = read
- `adr0` / `adr1` in AW: access address
- `wdata0` / `wdata1` in DW: write data
- `ack0` / `ack1` out 1: one-cycle completion pulse
- `rdata` out DW: read data, shared by both ports, valid when the matching ack is high
- `busy` out 1: high in any state other than IDLE
- `mem_adr` out AW, `mem_wdata` out DW: to memory
- `mem_read` / `mem_write` out 1: memory strobes
- `mem_rdata` in DW: from memory

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both requesting: grant the port not served last. `last` resets to 1, so port 0 wins the first tie.
  - On grant, latch port id, `we`, `adr` and `wdata` into registers, load `cnt = MEM_LAT-1`, update `last`, then go to ACCESS.
- ACCESS:
  - Drive `mem_adr` / `mem_wdata` from the latched registers.
  - Drive `mem_read = ~we_q` and `mem_write = we_q`.
  - Decrement `cnt` each cycle.
  - When `cnt == 0`:
    - Read: load `rdata` from `mem_rdata` at this edge.
    - Go to DONE.
- DONE:
  - Both strobes low.
  - Assert `ack` of the granted port only.
  - Return to IDLE.
- `rdata` is updated only by reads. Writes leave it unchanged.
- Request protocol:
  - The requester holds `req`, `we`, `adr` and `wdata` stable until it sees ack.
  - It must deassert `req` in the cycle after ack, unless it is issuing a new access.
  - Changes while not granted are ignored.
  - If `req` is dropped after the grant, the access still completes and is acked.
- `mem_write` is high for all MEM_LAT cycles. Repeated writes of the same word are intentional and harmless.

## Timing
- Reset values:
  - Outputs: `ack0`, `ack1`, `busy`, `mem_read`, `mem_write` = 0; `mem_adr`, `mem_wdata`, `rdata` = 0.
  - Internal: state = IDLE, `last` = 1.
- All outputs are registered or decoded from the state register only. There is no combinational path from `req*` to any output.
- Latency: request seen in IDLE at cycle t.
  - ACCESS occupies t+1 .. t+MEM_LAT.
  - ack is high at t+MEM_LAT+1.
- Throughput: one access per MEM_LAT+2 cycles. The next grant is decided in the IDLE cycle after DONE.
- A port re-requesting back-to-back while the other is waiting loses the tie (strict alternation under contention).
- Reset asserted mid-access: the next cycle is IDLE with strobes low. No ack is issued and the aborted access is not retried.
- `MEM_LAT = 1`: ACCESS lasts exactly one cycle and `cnt` is never decremented below 0.

## Structure
- Package `mem_arb_pkg`: state encoding constants (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the counter width constant (4).
- Sub-module `rr_pick2` (combinational, with `last` passed in):
  - Inputs: `req0`, `req1`, `last`.
  - Outputs: `gnt_valid`, `gnt_id`.
  - The FSM, latches and counter stay in `mem_arbiter`.

## Test plan
- Single read, MEM_LAT=1:
  - Stimulus: memory word 5 = 32'hDEAD_BEEF; `req0` with `we0=0`, `adr0=5`.
  - Required: `mem_read` high exactly 1 cycle; `ack0` two cycles after the request; `rdata = DEADBEEF`; `ack1` never high.
- Write then read, MEM_LAT=3:
  - Stimulus: port 1 writes 32'h1234 to address 8, then reads address 8.
  - Required: `mem_write` high 3 cycles; the write ack leaves `rdata` unchanged; the read ack returns 32'h1234; each ack arrives 4 cycles after its request.
- Simultaneous requests from reset:
  - Stimulus: `req0` and `req1` rise together and are held as required.
  - Required: port 0 acked first, port 1 acked MEM_LAT+2 cycles later.
  - Continuous requests from both then alternate grants 0, 1, 0, 1.
- Reset mid-access, MEM_LAT=4:
  - Stimulus: assert `rst` during the second ACCESS cycle.
  - Required: next cycle has strobes = 0, `busy` = 0 and no ack; `rdata` = 0.
- Idle and stability:
  - Stimulus: no requests for 20 cycles; then toggle `adr1` while `req1` = 0.
  - Required: strobes, `busy` and acks stay 0 throughout; `mem_adr` does not follow `adr1`.
